// File: rtl/sigmoid_sched.sv
// sigmoid_sched: round-robin two-requester scheduler sharing one pipelined sigmoid datapath
module sigmoid_sched #(
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [7:0]       req0_x,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [15:0]      rsp0_data,
    input  logic             rsp0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_x,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [15:0]      rsp1_data,
    input  logic             rsp1_ready,
    output logic             dp_valid,
    output logic [7:0]       dp_x,
    input  logic [15:0]      dp_out,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    logic [LAT:0]     tag_v_q, tag_v_d, tag_id_q, tag_id_d;
    logic             rr_q, rr_d, dp_valid_q, dp_valid_d;
    logic             rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
    logic [7:0]       dp_x_q, dp_x_d;
    logic [15:0]      rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
    logic [CNT_W-1:0] ops_q, ops_d;
    logic             el0, el1, g0, g1, cap0, cap1;

    always_comb begin
        el0          = req0_valid & ~(|(tag_v_q & ~tag_id_q) | rsp0_valid_q);
        el1          = req1_valid & ~(|(tag_v_q & tag_id_q) | rsp1_valid_q);
        g0           = el0 & (~el1 | ~rr_q);
        g1           = el1 & (~el0 | rr_q);
        tag_v_d      = {tag_v_q[LAT-1:0], g0 | g1};
        tag_id_d     = {tag_id_q[LAT-1:0], g1};
        rr_d         = (g0 | g1) ? g0 : rr_q;
        dp_valid_d   = g0 | g1;
        dp_x_d       = g0 ? req0_x : g1 ? req1_x : dp_x_q;
        cap0         = tag_v_q[LAT] & ~tag_id_q[LAT];
        cap1         = tag_v_q[LAT] & tag_id_q[LAT];
        rsp0_valid_d = cap0 | (rsp0_valid_q & ~rsp0_ready);
        rsp1_valid_d = cap1 | (rsp1_valid_q & ~rsp1_ready);
        rsp0_data_d  = cap0 ? dp_out : rsp0_data_q;
        rsp1_data_d  = cap1 ? dp_out : rsp1_data_q;
        ops_d        = ops_q + CNT_W'(rsp0_valid_q & rsp0_ready) + CNT_W'(rsp1_valid_q & rsp1_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            rr_q         <= 1'b0;
            dp_valid_q   <= 1'b0;
            dp_x_q       <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            ops_q        <= '0;
        end else begin
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            rr_q         <= rr_d;
            dp_valid_q   <= dp_valid_d;
            dp_x_q       <= dp_x_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
            ops_q        <= ops_d;
        end
    end

    assign req0_ready = g0;
    assign req1_ready = g1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign dp_valid   = dp_valid_q;
    assign dp_x       = dp_x_q;
    assign busy       = |tag_v_q | rsp0_valid_q | rsp1_valid_q;
    assign ops_done   = ops_q;
endmodule

// File: tb/tb_sigmoid_sched.sv
// tb_sigmoid_sched: scoreboard bench driving a LAT=1 and a LAT=3 (2-bit counter) instance in parallel
module tb_sigmoid_sched;
    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      rv_in, rr_in;
    logic [1:0][7:0] x_in;
    int              cyc = 0;
    int              checks = 0;
    int              errors = 0;
    int              acnt [2][2];
    int              snap [2][2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] sig(input logic [7:0] x);
        int v;
        v = 128 + 2 * int'($signed(x));
        return (v < 0) ? 16'd0 : (v > 256) ? 16'd256 : 16'(v);
    endfunction

    task automatic chk(input int g, input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", n, g, cyc, a, e);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int L  = (g == 0) ? 1 : 3;
        localparam int CW = (g == 0) ? 16 : 2;
        logic          rdy0, rdy1, rvo0, rvo1, dv, bsy;
        logic [1:0]    rdy, rvo, eg, el;
        logic [15:0]   rd0, rd1, dpo;
        logic [15:0]   rd [2];
        logic [7:0]    dpx, edx;
        logic [CW-1:0] ops, cnt;
        logic [7:0]    pipe [L];
        logic [15:0]   q [2][$];
        logic [15:0]   last [2];
        logic          ost [2];
        int            acc_c [2];
        logic          rr, edv, erv;

        sigmoid_sched #(.LAT(L), .CNT_W(CW)) dut (
            .clk(clk), .reset_n(reset_n),
            .req0_valid(rv_in[0]), .req0_x(x_in[0]), .req0_ready(rdy0),
            .rsp0_valid(rvo0), .rsp0_data(rd0), .rsp0_ready(rr_in[0]),
            .req1_valid(rv_in[1]), .req1_x(x_in[1]), .req1_ready(rdy1),
            .rsp1_valid(rvo1), .rsp1_data(rd1), .rsp1_ready(rr_in[1]),
            .dp_valid(dv), .dp_x(dpx), .dp_out(dpo), .busy(bsy), .ops_done(ops)
        );

        assign rdy   = {rdy1, rdy0};
        assign rvo   = {rvo1, rvo0};
        assign rd[0] = rd0;
        assign rd[1] = rd1;
        assign dpo   = sig(pipe[L-1]);

        always @(posedge clk) begin
            pipe[0] <= dpx;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end

        // issue side: every accepted operand queues its expected result
        always @(negedge clk)
            if (reset_n)
                for (int i = 0; i < 2; i++)
                    if (rv_in[i] && rdy[i]) q[i].push_back(sig(x_in[i]));

        always @(negedge clk) begin
            if (!reset_n) begin
                chk(g, "rst_ctrl", 32'({rdy, rvo, dv, bsy}), 32'd0);
                chk(g, "rst_data", 32'(rd0 | rd1 | 16'(dpx)), 32'd0);
                chk(g, "rst_ops", 32'(ops), 32'd0);
                cnt = '0; rr = 1'b0; edv = 1'b0; edx = '0;
                for (int i = 0; i < 2; i++) begin
                    ost[i] = 1'b0; last[i] = '0; acc_c[i] = 0; q[i].delete();
                end
            end else begin
                for (int i = 0; i < 2; i++) el[i] = rv_in[i] && !ost[i];
                eg[0] = el[0] && (!el[1] || !rr);
                eg[1] = el[1] && (!el[0] || rr);
                chk(g, "grant", 32'(rdy), 32'(eg));
                chk(g, "busy", 32'(bsy), 32'(ost[0] || ost[1]));
                chk(g, "ops_done", 32'(ops), 32'(cnt));
                chk(g, "dp_valid", 32'(dv), 32'(edv));
                chk(g, "dp_x", 32'(dpx), 32'(edx));
                for (int i = 0; i < 2; i++) begin
                    erv = ost[i] && (cyc >= acc_c[i] + L + 2);
                    chk(g, i ? "rsp1_valid" : "rsp0_valid", 32'(rvo[i]), 32'(erv));
                    if (rvo[i]) begin
                        chk(g, "rsp_queue", 32'(q[i].size() != 0), 32'd1);
                        if (q[i].size() != 0) begin
                            chk(g, i ? "rsp1_data" : "rsp0_data", 32'(rd[i]), 32'(q[i][0]));
                            last[i] = q[i][0];
                            if (rr_in[i]) begin
                                void'(q[i].pop_front());
                                ost[i] = 1'b0;
                                cnt    = cnt + 1'b1;
                            end
                        end
                    end else begin
                        chk(g, i ? "rsp1_hold" : "rsp0_hold", 32'(rd[i]), 32'(last[i]));
                    end
                end
                edv = 1'b0;
                for (int i = 0; i < 2; i++)
                    if (rv_in[i] && rdy[i]) begin
                        ost[i] = 1'b1; acc_c[i] = cyc; rr = (i == 0);
                        edv = 1'b1; edx = x_in[i]; acnt[g][i]++;
                    end
            end
        end
    end

    task automatic step(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] r, input int n);
        rv_in = v; x_in[0] = a; x_in[1] = b; rr_in = r;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rst_pulse();
        reset_n = 1'b0;
        step(2'b00, 8'h00, 8'h00, 2'b11, 1);
        reset_n = 1'b1;
    endtask

    initial begin
        int d0, d1, lat;
        reset_n = 1'b0;
        step(2'b00, 8'h00, 8'h00, 2'b11, 3);
        reset_n = 1'b1;
        step(2'b01, 8'h40, 8'h00, 2'b11, 1);
        step(2'b00, 8'h00, 8'h00, 2'b11, 10);
        rst_pulse();
        step(2'b11, 8'h00, 8'hC0, 2'b00, 2);
        step(2'b00, 8'h00, 8'h00, 2'b00, 8);
        step(2'b00, 8'h00, 8'h00, 2'b11, 5);
        repeat (10) step(2'b11, 8'($urandom), 8'($urandom), 2'b10, 1);
        step(2'b11, 8'h7F, 8'h80, 2'b11, 6);
        for (int g = 0; g < 2; g++) for (int i = 0; i < 2; i++) snap[g][i] = acnt[g][i];
        repeat (40) step(2'b11, 8'($urandom), 8'($urandom), 2'b11, 1);
        for (int g = 0; g < 2; g++) begin
            lat = (g == 0) ? 1 : 3;
            d0  = acnt[g][0] - snap[g][0];
            d1  = acnt[g][1] - snap[g][1];
            chk(g, "fair_diff", 32'(d0 - d1 <= 1 && d1 - d0 <= 1), 32'd1);
            chk(g, "fair_total", 32'(d0 + d1 >= 2 * (40 / (lat + 3)) - 2), 32'd1);
        end
        repeat (1500)
            step(2'($urandom), 8'($urandom), 8'($urandom),
                 {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0}, 1);
        step(2'b00, 8'h00, 8'h00, 2'b11, 20);
        step(2'b10, 8'h00, 8'h40, 2'b11, 1);
        step(2'b00, 8'h00, 8'h00, 2'b11, 1);
        rst_pulse();
        step(2'b00, 8'h00, 8'h00, 2'b11, 12);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
